mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl_pkg.sv | 63 ++++++
 rtl/mc_ctrl_outdec.sv | 79 +++++++
 rtl/mips_multicycle_ctrl.sv | 95 +++++++++
 tb/tb_mips_multicycle_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_multicycle_ctrl_pkg: state codes, opcodes, datapath encodings and the control-word layout.
// Defining MC_CTRL_ADDI_EN turns on the addi states (ADDIEX/ADDIWB).
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MC_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: Moore state-to-control-word decode; addi states decode only with MC_CTRL_ADDI_EN.
module mc_ctrl_outdec
    import mips_multicycle_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SHIMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            // without the addi feature these codes fall through as all-zero
            S_ADDIEX: begin
                ctrl.alu_src_a = ADDI_EN;
                ctrl.alu_src_b = ADDI_EN ? SRCB_IMM : 2'b00;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = ADDI_EN;
                ctrl.instr_done = ADDI_EN;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM, opcode latch and retired-instruction counter.
// Defining MC_CTRL_ADDI_EN adds addi (opcode 001000) via ADDIEX/ADDIWB.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal;
    ctrl_t            ctrl;

    mc_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d    = opcode;
                state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                          opcode == OP_RTYPE                  ? S_EXEC   :
                          opcode == OP_BEQ                    ? S_BRANCH :
                          opcode == OP_J                      ? S_JUMP   :
                          (ADDI_EN && opcode == OP_ADDI)      ? S_ADDIEX : S_FETCH;
                illegal = state_d == S_FETCH;
            end
            S_MEMADR: state_d = op_q == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RTWB;
            S_ADDIEX: state_d = ADDI_EN ? S_ADDIWB : S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        cnt_d = cnt_q + CNT_W'(ctrl.instr_done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign instr_done  = ctrl.instr_done;
    assign illegal_op  = illegal;
    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of the multicycle control FSM and its counter.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, RegWrite, RegDst, ALUSrcA, instr_done, illegal_op;
    logic [1:0]  ALUOp, ALUSrcB, PCSource;
    logic [15:0] instr_count;
    logic [3:0]  state;

    wire [9:0]   s_str;
    wire [1:0]   s_aluop, s_srcb, s_pcsrc;
    wire         s_done, s_ill;
    wire [3:0]   s_cnt, s_state;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count), .state(state)
    );

    // narrow counter copy reaches its all-ones wrap point within a short run
    mips_multicycle_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .opcode(opcode),
        .PCWrite(s_str[0]), .PCWriteCond(s_str[1]), .IorD(s_str[2]),
        .MemRead(s_str[3]), .MemWrite(s_str[4]), .MemtoReg(s_str[5]),
        .IRWrite(s_str[6]), .RegWrite(s_str[7]), .RegDst(s_str[8]),
        .ALUSrcA(s_str[9]), .ALUOp(s_aluop), .ALUSrcB(s_srcb),
        .PCSource(s_pcsrc), .instr_done(s_done), .illegal_op(s_ill),
        .instr_count(s_cnt), .state(s_state)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        opcode = 6'b100011;
        repeat (2) step;
        vectors++;
        if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
        vectors++;
        if (instr_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0h want 0", instr_count); end
        vectors++;
        if ({MemRead, IRWrite, PCWrite, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op} !== 11'b111_01_00_00_0_0) begin
            miscompares++;
            $display("FAIL reset_fetch_outs: got %b want 11101000000",
                     {MemRead, IRWrite, PCWrite, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op});
        end
        reset = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_lw;
        int exp_st[5] = '{0, 1, 2, 3, 4};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state !== 4'(exp_st[i])) begin miscompares++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (i == 1) begin
                vectors++;
                if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b0_11_00) begin miscompares++; $display("FAIL decode_outs: got %b want 01100", {ALUSrcA, ALUSrcB, ALUOp}); end
            end
            if (i == 2) begin
                vectors++;
                if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b1_10_00) begin miscompares++; $display("FAIL memadr_outs: got %b want 11000", {ALUSrcA, ALUSrcB, ALUOp}); end
            end
            if (i == 3) begin
                vectors++;
                if ({MemRead, IorD, IRWrite, PCWrite, instr_done} !== 5'b11000) begin miscompares++; $display("FAIL memrd_outs: got %b want 11000", {MemRead, IorD, IRWrite, PCWrite, instr_done}); end
            end
            if (i == 4) begin
                vectors++;
                if ({RegWrite, MemtoReg, RegDst, instr_done} !== 4'b1101) begin miscompares++; $display("FAIL memwb_outs: got %b want 1101", {RegWrite, MemtoReg, RegDst, instr_done}); end
            end
            step;
        end
        exp_cnt++;
        vectors++;
        if (state !== 4'd0) begin miscompares++; $display("FAIL lw_end_state: got %0d want 0", state); end
        vectors++;
        if (instr_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL lw_count: got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_sw_rtype;
        int exp_sw[4] = '{0, 1, 2, 5};
        int exp_rt[4] = '{0, 1, 6, 7};
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state !== 4'(exp_sw[i])) begin miscompares++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_sw[i]); end
            if (i == 3) begin
                vectors++;
                if ({MemWrite, IorD, MemRead, RegWrite, instr_done} !== 5'b11001) begin miscompares++; $display("FAIL memwr_outs: got %b want 11001", {MemWrite, IorD, MemRead, RegWrite, instr_done}); end
            end
            step;
        end
        exp_cnt++;
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state !== 4'(exp_rt[i])) begin miscompares++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_rt[i]); end
            if (i == 2) begin
                vectors++;
                if ({ALUSrcA, ALUSrcB, ALUOp, instr_done} !== 6'b1_00_10_0) begin miscompares++; $display("FAIL exec_outs: got %b want 100100", {ALUSrcA, ALUSrcB, ALUOp, instr_done}); end
            end
            if (i == 3) begin
                vectors++;
                if ({RegWrite, RegDst, MemtoReg, instr_done} !== 4'b1101) begin miscompares++; $display("FAIL rtwb_outs: got %b want 1101", {RegWrite, RegDst, MemtoReg, instr_done}); end
            end
            step;
        end
        exp_cnt++;
        vectors++;
        if (instr_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL sw_rtype_count: got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_beq_j;
        opcode = 6'b000100;
        step;
        step;
        vectors++;
        if (state !== 4'd8) begin miscompares++; $display("FAIL beq_state: got %0d want 8", state); end
        vectors++;
        if ({PCWriteCond, PCWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done} !== 10'b1_0_1_00_01_01_1) begin
            miscompares++;
            $display("FAIL branch_outs: got %b want 1010001011", {PCWriteCond, PCWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done});
        end
        step;
        exp_cnt++;
        vectors++;
        if (state !== 4'd0) begin miscompares++; $display("FAIL beq_len: got state %0d want 0 after 3 cycles", state); end
        opcode = 6'b000010;
        step;
        step;
        vectors++;
        if (state !== 4'd9) begin miscompares++; $display("FAIL j_state: got %0d want 9", state); end
        vectors++;
        if ({PCWrite, PCWriteCond, PCSource, ALUSrcA, instr_done} !== 6'b1_0_10_0_1) begin
            miscompares++;
            $display("FAIL jump_outs: got %b want 101001", {PCWrite, PCWriteCond, PCSource, ALUSrcA, instr_done});
        end
        step;
        exp_cnt++;
        vectors++;
        if (state !== 4'd0) begin miscompares++; $display("FAIL j_len: got state %0d want 0 after 3 cycles", state); end
        vectors++;
        if (instr_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL beq_j_count: got %0d want %0d", instr_count, exp_cnt); end
    endtask

    task automatic test_illegal(input logic [5:0] op, input string name);
        opcode = op;
        vectors++;
        if (illegal_op !== 1'b0) begin miscompares++; $display("FAIL %s_ill_fetch: got %b want 0", name, illegal_op); end
        step;
        vectors++;
        if ({state, illegal_op, instr_done} !== 6'b0001_1_0) begin miscompares++; $display("FAIL %s_decode: got st=%0d ill=%b done=%b want st=1 ill=1 done=0", name, state, illegal_op, instr_done); end
        step;
        vectors++;
        if ({state, illegal_op} !== 5'b0000_0) begin miscompares++; $display("FAIL %s_next: got st=%0d ill=%b want st=0 ill=0", name, state, illegal_op); end
        vectors++;
        if (instr_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL %s_count: got %0d want %0d", name, instr_count, exp_cnt); end
    endtask

    task automatic test_addi;
`ifdef MC_CTRL_ADDI_EN
        int exp_st[4] = '{0, 1, 10, 11};
        opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state !== 4'(exp_st[i])) begin miscompares++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (i == 1) begin
                vectors++;
                if (illegal_op !== 1'b0) begin miscompares++; $display("FAIL addi_ill: got %b want 0", illegal_op); end
            end
            if (i == 2) begin
                vectors++;
                if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b1_10_00) begin miscompares++; $display("FAIL addiex_outs: got %b want 11000", {ALUSrcA, ALUSrcB, ALUOp}); end
            end
            if (i == 3) begin
                vectors++;
                if ({RegWrite, RegDst, MemtoReg, instr_done} !== 4'b1001) begin miscompares++; $display("FAIL addiwb_outs: got %b want 1001", {RegWrite, RegDst, MemtoReg, instr_done}); end
            end
            step;
        end
        exp_cnt++;
        vectors++;
        if (instr_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL addi_count: got %0d want %0d", instr_count, exp_cnt); end
`else
        test_illegal(6'b001000, "addi_off");
`endif
    endtask

    task automatic test_reset_mid;
        opcode = 6'b100011;
        repeat (3) step;
        vectors++;
        if (state !== 4'd3) begin miscompares++; $display("FAIL mid_pre_state: got %0d want 3", state); end
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        vectors++;
        if ({state, instr_count} !== 20'h0_0000) begin miscompares++; $display("FAIL mid_async: got st=%0d cnt=%0h want st=0 cnt=0", state, instr_count); end
        opcode = 6'b000010;
        @(negedge clk);
        reset = 1'b0;
        step;
        vectors++;
        if (state !== 4'd1) begin miscompares++; $display("FAIL first_edge_fetch: got %0d want 1", state); end
        step;
        step;
        exp_cnt++;
        vectors++;
        if ({state, instr_count} !== {4'd0, 16'(exp_cnt)}) begin miscompares++; $display("FAIL mid_after_j: got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_count, exp_cnt); end
    endtask

    task automatic test_wrap;
        reset = 1'b1;
        step;
        reset = 1'b0;
        opcode = 6'b000010;
        repeat (15) repeat (3) step;
        vectors++;
        if (s_cnt !== 4'hF) begin miscompares++; $display("FAIL wrap_preload: got %0h want f", s_cnt); end
        vectors++;
        if (instr_count !== 16'd15) begin miscompares++; $display("FAIL wrap_wide_15: got %0d want 15", instr_count); end
        repeat (3) step;
        vectors++;
        if (s_cnt !== 4'h0) begin miscompares++; $display("FAIL wrap_to_zero: got %0h want 0", s_cnt); end
        vectors++;
        if (instr_count !== 16'd16) begin miscompares++; $display("FAIL wrap_wide_16: got %0d want 16", instr_count); end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'b0;
        @(negedge clk);
        test_reset;
        test_lw;
        test_sw_rtype;
        test_beq_j;
        test_illegal(6'b111111, "illegal");
        test_addi;
        test_reset_mid;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
